// File: rtl/sar_comparator_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_comparator_search_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } sar_state_e;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned MaxWidth     = 16;

endpackage

// File: rtl/sar_comparator_search.sv
// Successive-approximation controller: drives trial values onto a comparator's B operand
// and recovers the unknown A operand one bit per cycle, MSB first.
module sar_comparator_search
  import sar_comparator_search_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ageqb,
  output logic [Width-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] result
);

  if (Width < 2 || Width > MaxWidth) begin : g_width_check
    $error("sar_comparator_search: Width out of range");
  end

  localparam logic [Width-1:0] MaskMsb = {1'b1, {(Width-1){1'b0}}};

  sar_state_e       state_q;
  logic [Width-1:0] acc_q;
  logic [Width-1:0] mask_q;
  logic [Width-1:0] result_q;
  logic             start_ok;
  logic             last_bit;

  // Start is only honoured outside SEARCH; a search cannot be aborted except by reset.
  assign start_ok = (state_q != StSearch) && start;
  assign last_bit = mask_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (start) state_q <= StSearch;
        StSearch: if (last_bit) state_q <= StDone;
        StDone:   state_q <= start ? StSearch : StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
    end else if (start_ok) begin
      acc_q  <= '0;
      mask_q <= MaskMsb;
    end else if (state_q == StSearch) begin
      if (ageqb) acc_q <= acc_q | mask_q;
      mask_q <= mask_q >> 1;
      if (last_bit) result_q <= ageqb ? (acc_q | mask_q) : acc_q;
    end
  end

  // Trial comes only from registers, so input changes cannot ripple back through the comparator.
  always_comb begin
    trial = result_q;
    if (state_q == StSearch) trial = acc_q | mask_q;
  end

  assign busy   = (state_q == StSearch);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_sar_comparator_search.sv
// Directed bench: behavioural comparators close the loop around Width=4 and Width=8 instances.
module tb_sar_comparator_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0;
  logic       start8 = 1'b0;
  logic [3:0] a4 = '0;
  logic [7:0] a8 = '0;
  logic       ageqb4, ageqb8;
  logic [3:0] trial4, result4;
  logic [7:0] trial8, result8;
  logic       busy4, done4, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Comparator models: flag is combinational from trial.
  assign ageqb4 = (a4 >= trial4);
  assign ageqb8 = (a8 >= trial8);

  sar_comparator_search #(.Width(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ageqb(ageqb4),
    .trial(trial4), .busy(busy4), .done(done4), .result(result4)
  );

  sar_comparator_search #(.Width(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ageqb(ageqb8),
    .trial(trial8), .busy(busy8), .done(done8), .result(result8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; pulses start for one cycle, then follows the search cycle by cycle.
  task automatic run4(input string tag, input logic [3:0] a, input logic [15:0] trials,
                      input logic [3:0] flags, input logic [3:0] res);
    a4 = a;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_trial"}, 32'(trial4), 32'(trials[15-4*i -: 4]));
      check({tag, "_ageqb"}, 32'(ageqb4), 32'(flags[3-i]));
      check({tag, "_busy"}, 32'(busy4), 32'd1);
      check({tag, "_done_early"}, 32'(done4), 32'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done4), 32'd1);
    check({tag, "_busy_off"}, 32'(busy4), 32'd0);
    check({tag, "_result"}, 32'(result4), 32'(res));
    check({tag, "_trial_done"}, 32'(trial4), 32'(res));
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done4), 32'd0);
    check({tag, "_idle"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    logic [15:0] bb_trials;
    logic [63:0] t8;
    int          dones;

    // Reset state
    #2;
    check("rst_trial", 32'(trial4), 32'd0);
    check("rst_result", 32'(result4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy4), 32'd0);

    run4("a10", 4'd10, 16'h8CAB, 4'b1010, 4'd10);
    run4("a0",  4'd0,  16'h8421, 4'b0000, 4'd0);
    run4("a15", 4'd15, 16'h8CEF, 4'b1111, 4'd15);

    // Back-to-back: start held high, A=5 then A=6 changed in DONE
    a4 = 4'd5;
    start4 = 1'b1;
    dones = 0;
    bb_trials = 16'h8465;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bb1_trial", 32'(trial4), 32'(bb_trials[15-4*i -: 4]));
      @(negedge clk);
    end
    check("bb1_done", 32'(done4), 32'd1);
    check("bb1_result", 32'(result4), 32'd5);
    a4 = 4'd6;
    bb_trials = 16'h8467;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bb2_trial", 32'(trial4), 32'(bb_trials[15-4*i -: 4]));
      check("bb2_busy", 32'(busy4), 32'd1);
      if (done4) dones++;
      @(negedge clk);
    end
    check("bb2_done", 32'(done4), 32'd1);
    check("bb2_result", 32'(result4), 32'd6);
    check("bb2_no_extra_done", 32'(dones), 32'd0);
    start4 = 1'b0;
    @(negedge clk);
    check("bb_idle", 32'(busy4), 32'd0);

    // Start re-pulsed during SEARCH cycle 2 is ignored
    a4 = 4'd3;
    start4 = 1'b1;
    dones = 0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("ign_trial_c3", 32'(trial4), 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("ign_done", 32'(done4), 32'd1);
    check("ign_result", 32'(result4), 32'd3);
    @(negedge clk);
    check("ign_single_done", 32'(done4), 32'd0);
    check("ign_idle", 32'(busy4), 32'd0);

    // Asynchronous reset in cycle 3 of a search with A=9
    a4 = 4'd9;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_trial_pre", 32'(trial4), 32'd10);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_done", 32'(done4), 32'd0);
    check("arst_trial", 32'(trial4), 32'd0);
    check("arst_result", 32'(result4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy4), 32'd0);
      check("post_rst_done", 32'(done4), 32'd0);
      check("post_rst_result", 32'(result4), 32'd0);
    end
    run4("a9", 4'd9, 16'h8CA9, 4'b1001, 4'd9);

    // Width=8, A=0xA5
    a8 = 8'hA5;
    t8 = 64'h80C0A0B0A8A4A6A5;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("w8_trial", 32'(trial8), 32'(t8[63-8*i -: 8]));
      check("w8_busy", 32'(busy8), 32'd1);
      @(negedge clk);
    end
    check("w8_done", 32'(done8), 32'd1);
    check("w8_result", 32'(result8), 32'hA5);
    @(negedge clk);
    check("w8_done_once", 32'(done8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_comparator_search.md
# sar_comparator_search

Successive-approximation search controller that sits on the opposite side of a magnitude comparator: it drives the comparator's B operand with trial values, reads back the A-greater-or-equal-B flag, and recovers the unknown value on A one bit per cycle, MSB first. It is used to digitise an external quantity that is visible only through a comparator, such as a DAC and analog comparator or the team's 2-bit equality/magnitude comparator widened to WIDTH bits.

## Interface
- WIDTH, 4: width of the trial and result words; legal range is 2 to 16.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  request a new search; sampled only in IDLE or DONE.
- AgeqB  in  1  comparator flag, high when unknown A >= Trial; combinational from Trial, sampled on each rising edge in SEARCH.
- Trial  out  WIDTH  value driven onto the comparator B operand.
- Busy  out  1  high throughout SEARCH.
- Done  out  1  high for exactly one cycle, in DONE.
- Result  out  WIDTH  recovered value; valid from DONE onward and held until the next accepted Start.

## Operation
- States and transitions:
  - IDLE: Start=1 moves to SEARCH.
  - SEARCH: after WIDTH cycles, moves to DONE.
  - DONE: Start=1 moves to SEARCH; Start=0 moves to IDLE.
- Registers:
  - acc: WIDTH-bit accumulator.
  - mask: WIDTH-bit one-hot bit pointer.
- On Start acceptance: acc <= 0 and mask <= 1<<(WIDTH-1).
- Trial:
  - In SEARCH, Trial = acc | mask (combinational from registers, so there is no Trial-to-Trial glitch path from inputs).
  - In IDLE and DONE, Trial = Result.
- Each SEARCH edge:
  - If AgeqB=1, then acc <= acc | mask; otherwise acc is unchanged.
  - mask <= mask >> 1.
  - When mask==1 is consumed, the next state is DONE and Result <= final acc.
- Start while in SEARCH is ignored; there is no abort other than Resetn.
- AgeqB is ignored outside SEARCH.
- Result keeps its old value during SEARCH; it updates only on the SEARCH-to-DONE edge.
- No arithmetic is needed; only OR and shift, with no carries. mask is never zero inside SEARCH.

## Timing
- Reset values (Resetn=0, asynchronous): state=IDLE, acc=0, mask=0, Result=0, Trial=0, Busy=0, Done=0.
- Latency:
  - Start sampled high at edge E0 puts the block in SEARCH on cycle 1.
  - Bits are decided at edges E1..EWIDTH.
  - Done=1 during cycle WIDTH+1.
  - With WIDTH=4, Done appears 5 cycles after the Start edge.
- Back-to-back operation: Start held high in DONE begins the next search immediately, giving a throughput of one result per WIDTH+1 cycles.
- Reset mid-SEARCH: all outputs return to reset values immediately. After Resetn deasserts, the block waits in IDLE; no partial Result is ever presented.
- Resetn deassertion is synchronised externally; the block only requires that deassertion not coincide with the rising edge of Clock.
- The external comparator must settle AgeqB within one Clock period of a Trial change.

## Structure
- Shared package holds:
  - the state enum {IDLE, SEARCH, DONE}, 2 bits;
  - the WIDTH default constant;
  - MAX_WIDTH=16, for a parameter range check.
- RTL is a single module: one state register process, one acc/mask/Result datapath process, and combinational output decode.
- No RTL sub-module is needed. The bench uses a behavioural comparator model, cmp_model, which computes AgeqB = (A >= Trial) for a programmable A.

## Test plan
- Reset, then A=10 and a 1-cycle Start pulse, at WIDTH=4:
  - Trial sequence is 8, 12, 10, 11.
  - AgeqB sequence is 1, 0, 1, 0.
  - Done appears 5 cycles after Start with Result=10, and Busy is high for exactly 4 cycles.
- Boundary values at WIDTH=4:
  - A=0: Trial sequence 8, 4, 2, 1, and Result=0.
  - A=15: Trial sequence 8, 12, 14, 15, and Result=15.
- Start held high continuously with A=5 and then A=6 (A changed in DONE):
  - The first Result is 5 and the second Result is 6.
  - Done pulses every 5 cycles, and the second search's first Trial=8 appears in the cycle after DONE.
- Start pulsed again during SEARCH (cycle 2) with A=3: it is ignored. Result=3 arrives on the original schedule, with a single Done pulse.
- Resetn asserted during cycle 3 of a search with A=9:
  - Busy, Done, Trial and Result all go to 0 asynchronously, before the next edge.
  - After release, the block stays in IDLE until Start is pulsed, then returns Result=9.
- WIDTH=8 with A=0xA5: Result=0xA5 after 9 cycles, confirming the MSB-first mask walk.
